inst_fetch_unit: RTL and testbench

//  Instruction fetch front end: owns the PC, drives the word address into the

---
 rtl/inst_fetch_unit_if.sv | 23 ++
 rtl/inst_fetch_unit.sv | 56 +++++
 tb/tb_inst_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus: ROM address/data, redirect request and the decode handshake.
// master = fetch unit, slave = ROM / decode / branch resolution side.
interface inst_fetch_unit_if;
    logic        fetch_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        input  fetch_en, rom_inst, redirect_valid, redirect_pc, id_ready,
        output rom_addr, id_valid, id_inst, id_pc
    );

    modport slave (
        output fetch_en, rom_inst, redirect_valid, redirect_pc, id_ready,
        input  rom_addr, id_valid, id_inst, id_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, combinational ROM lookup and a
// 2-entry {pc, inst} FIFO toward decode with redirect flush.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_unit_if.master  bus
);
    localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;

    logic [31:0]       pc;
    logic [1:0][31:0]  fifo_pc;
    logic [1:0][31:0]  fifo_inst;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    assign bus.rom_addr = pc;
    assign bus.id_valid = (count != 2'd0);
    assign bus.id_pc    = fifo_pc[rd_ptr];
    assign bus.id_inst  = fifo_inst[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = bus.id_valid & bus.id_ready;
    assign push = bus.fetch_en & ~bus.redirect_valid & ((count != 2'd2) | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= PC_INIT;
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            fifo_pc   <= '0;
            fifo_inst <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc & ~32'd3;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= pc;
                fifo_inst[wr_ptr] <= bus.rom_inst;
                wr_ptr            <= ~wr_ptr;
                pc                <= pc + PC_STEP;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a synthetic ROM returns 0xC0DE00xx
// where xx is the word index, so every id_inst is predictable from its pc.
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_unit_if bus ();
    inst_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rom_inst = 32'hC0DE_0000 | {26'h0, bus.rom_addr[7:2]};

    function automatic logic [31:0] rom_of(input logic [31:0] a);
        return 32'hC0DE_0000 | {26'h0, a[7:2]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.fetch_en = 1'b0;
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.id_valid); end
        checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", bus.id_inst); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", bus.id_pc); end
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h exp 0", bus.rom_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        rst_n = 1'b1;
        bus.fetch_en = 1'b1;
        bus.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            checks++; if (bus.rom_addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_rom_addr[%0d]: got %h exp %h", k, bus.rom_addr, 32'(4 * k)); end
            if (k > 0) begin
                checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp 1", k, bus.id_valid); end
                checks++; if (bus.id_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL seq_id_pc[%0d]: got %h exp %h", k, bus.id_pc, 32'(4 * (k - 1))); end
                checks++; if (bus.id_inst !== rom_of(32'(4 * (k - 1)))) begin errors++; $display("FAIL seq_id_inst[%0d]: got %h exp %h", k, bus.id_inst, rom_of(32'(4 * (k - 1)))); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_rom;
        do_reset();
        rst_n = 1'b1;
        bus.fetch_en = 1'b1;
        bus.id_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp_rom = (k >= 2) ? 32'h8 : 32'h4;
            checks++; if (bus.rom_addr !== exp_rom) begin errors++; $display("FAIL stall_rom_addr[%0d]: got %h exp %h", k, bus.rom_addr, exp_rom); end
            checks++; if (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL stall_head[%0d]: got pc %h v %b exp pc 0 v 1", k, bus.id_pc, bus.id_valid); end
        end
        bus.id_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (bus.id_pc !== 32'(4 * k) || bus.id_valid !== 1'b1) begin errors++; $display("FAIL stall_resume[%0d]: got pc %h v %b exp pc %h v 1", k, bus.id_pc, bus.id_valid, 32'(4 * k)); end
            checks++; if (bus.id_inst !== rom_of(32'(4 * k))) begin errors++; $display("FAIL stall_resume_inst[%0d]: got %h exp %h", k, bus.id_inst, rom_of(32'(4 * k))); end
        end
    endtask

    task automatic test_redirect();
        bus.id_ready = 1'b0;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0033;
        step();
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b exp 0", bus.id_valid); end
        checks++; if (bus.rom_addr !== 32'h30) begin errors++; $display("FAIL redir_rom_addr: got %h exp 30", bus.rom_addr); end
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h30) begin errors++; $display("FAIL redir_target: got pc %h v %b exp pc 30 v 1", bus.id_pc, bus.id_valid); end
        checks++; if (bus.id_inst !== rom_of(32'h30)) begin errors++; $display("FAIL redir_inst: got %h exp %h", bus.id_inst, rom_of(32'h30)); end
        checks++; if (bus.rom_addr !== 32'h34) begin errors++; $display("FAIL redir_next_rom: got %h exp 34", bus.rom_addr); end
        step();
        checks++; if (bus.id_pc !== 32'h34) begin errors++; $display("FAIL redir_next_pc: got %h exp 34", bus.id_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_rom [3];
        logic [31:0] exp_pc [3];
        exp_rom = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.rom_addr !== 32'hFFFF_FFF8 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL wrap_start: got rom %h v %b exp rom fffffff8 v 0", bus.rom_addr, bus.id_valid); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.rom_addr !== exp_rom[k]) begin errors++; $display("FAIL wrap_rom_addr[%0d]: got %h exp %h", k, bus.rom_addr, exp_rom[k]); end
            checks++; if (bus.id_pc !== exp_pc[k] || bus.id_valid !== 1'b1) begin errors++; $display("FAIL wrap_id_pc[%0d]: got %h v %b exp %h v 1", k, bus.id_pc, bus.id_valid, exp_pc[k]); end
            checks++; if ($isunknown({bus.id_valid, bus.id_inst, bus.id_pc, bus.rom_addr})) begin errors++; $display("FAIL wrap_no_x[%0d]: got unknown bits exp none", k); end
        end
    endtask

    task automatic test_drain();
        bus.id_ready = 1'b0;
        step();
        checks++; if (bus.rom_addr !== 32'h8 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL drain_fill: got rom %h pc %h exp rom 8 pc 0", bus.rom_addr, bus.id_pc); end
        bus.fetch_en = 1'b0;
        bus.id_ready = 1'b1;
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4) begin errors++; $display("FAIL drain_pop1: got v %b pc %h exp v 1 pc 4", bus.id_valid, bus.id_pc); end
        step();
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b exp 0", bus.id_valid); end
        step();
        checks++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h8) begin errors++; $display("FAIL drain_hold: got v %b rom %h exp v 0 rom 8", bus.id_valid, bus.rom_addr); end
        bus.fetch_en = 1'b1;
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.rom_addr !== 32'hC) begin errors++; $display("FAIL drain_resume: got v %b pc %h rom %h exp v 1 pc 8 rom c", bus.id_valid, bus.id_pc, bus.rom_addr); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h0 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL async_reset: got v %b rom %h pc %h exp v 0 rom 0 pc 0", bus.id_valid, bus.rom_addr, bus.id_pc); end
        step();
        rst_n = 1'b1;
        checks++; if (bus.rom_addr !== 32'h0) begin errors++; $display("FAIL async_restart0: got %h exp 0", bus.rom_addr); end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (bus.rom_addr !== 32'(4 * k) || bus.id_pc !== 32'(4 * (k - 1)) || bus.id_valid !== 1'b1) begin errors++; $display("FAIL async_restart[%0d]: got rom %h pc %h v %b exp rom %h pc %h v 1", k, bus.rom_addr, bus.id_pc, bus.id_valid, 32'(4 * k), 32'(4 * (k - 1))); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_drain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
